// File: rtl/instr_fetch_issue_pkg.sv
// Shared types and constants for the IF-stage fetch/issue block.
// Build option: FETCH_STATS_EN adds bubble/flush statistics counters to instr_fetch_issue.
package instr_fetch_issue_pkg;

    localparam int ISIZE = 16;

    localparam logic [ISIZE-1:0] NOP_WORD = 16'h7000;
    localparam logic [3:0]       OP_EXEC  = 4'h8;

    typedef enum logic [1:0] {
        FS_BOOT   = 2'd0,
        FS_RUN    = 2'd1,
        FS_BUBBLE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_issue_fetch_history.sv
// Issue register plus two history stages feeding the 3-back tap; every stage
// shifts on every clock, bubbles included, so the pre-decoder sees exact issue order.
module fetch_history
    import instr_fetch_issue_pkg::*;
#(
    parameter logic [ISIZE-1:0] NOP = NOP_WORD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ISIZE-1:0] issue_d,
    output logic [ISIZE-1:0] issue_q,
    output logic [ISIZE-1:0] last3_q
);

    // stage 0 = issue, 1 = h1, 2 = h2, 3 = last3
    logic [ISIZE-1:0] stage_q [0:3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                stage_q[i] <= NOP;
            end
        end else begin
            stage_q[0] <= issue_d;
            for (int i = 1; i < 4; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign issue_q = stage_q[0];
    assign last3_q = stage_q[3];

endmodule

// File: rtl/instr_fetch_issue.sv
// IF stage: owns the PC, issues imem words or NOP bubbles per the pre-decoder hazard inputs.
// Build option: FETCH_STATS_EN adds saturating bubble_cnt/flush_cnt outputs.
module instr_fetch_issue
    import instr_fetch_issue_pkg::*;
#(
    parameter int               ASIZE     = 16,
    parameter logic [ASIZE-1:0] RESET_PC  = '0,
    parameter logic [ISIZE-1:0] NOP_INSTR = NOP_WORD,
    parameter int               MAX_STALL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_en,
    input  logic             instr_sel,
    input  logic             branch_taken,
    input  logic [ASIZE-1:0] branch_target,
    output logic [ASIZE-1:0] imem_addr,
    input  logic [ISIZE-1:0] imem_data,
    output logic [ISIZE-1:0] issue_instr,
    output logic [ISIZE-1:0] last3_instr,
    output logic [ASIZE-1:0] issue_pc,
    output logic             bubble_q,
    output logic             stall_err
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]      bubble_cnt,
    output logic [15:0]      flush_cnt
`endif
);

    localparam logic [3:0] MAX_STALL_C = 4'(MAX_STALL);

    fetch_state_e     state_q, state_d;
    logic [ASIZE-1:0] pc_q, pc_d;
    logic [ASIZE-1:0] issue_pc_q, issue_pc_d;
    logic [ISIZE-1:0] issue_d;
    logic             bubble_d;
    logic [3:0]       stall_run_q, stall_run_d;
    logic             stall_err_q, stall_err_d;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        issue_d     = NOP_INSTR;
        issue_pc_d  = issue_pc_q;
        bubble_d    = 1'b1;
        stall_run_d = stall_run_q;

        if (state_q == FS_BOOT) begin
            state_d = FS_RUN;
        end else begin
            if (branch_taken) begin
                pc_d        = branch_target;
                stall_run_d = '0;
            end else if (instr_sel) begin
                if (pc_en) pc_d = pc_q + ASIZE'(1);
                if (stall_run_q < MAX_STALL_C) stall_run_d = stall_run_q + 4'd1;
            end else begin
                issue_d     = imem_data;
                issue_pc_d  = pc_q;
                bubble_d    = 1'b0;
                stall_run_d = '0;
                if (pc_en) pc_d = pc_q + ASIZE'(1);
            end
            state_d = bubble_d ? FS_BUBBLE : FS_RUN;
        end

        // Set on the same edge that issues the MAX_STALL-th consecutive bubble.
        stall_err_d = stall_err_q | (stall_run_d == MAX_STALL_C);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FS_BOOT;
            pc_q        <= RESET_PC;
            issue_pc_q  <= '0;
            bubble_q    <= 1'b1;
            stall_run_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            issue_pc_q  <= issue_pc_d;
            bubble_q    <= bubble_d;
            stall_run_q <= stall_run_d;
            stall_err_q <= stall_err_d;
        end
    end

    fetch_history #(
        .NOP (NOP_INSTR)
    ) u_history (
        .clk     (clk),
        .rst     (rst),
        .issue_d (issue_d),
        .issue_q (issue_instr),
        .last3_q (last3_instr)
    );

    assign imem_addr = pc_q;
    assign issue_pc  = issue_pc_q;
    assign stall_err = stall_err_q;

`ifdef FETCH_STATS_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        active;

    always_comb begin
        active       = (state_q != FS_BOOT);
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (active && branch_taken && (flush_cnt_q != 16'hFFFF))
            flush_cnt_d = flush_cnt_q + 16'd1;
        if (active && !branch_taken && instr_sel && (bubble_cnt_q != 16'hFFFF))
            bubble_cnt_d = bubble_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Bench for instr_fetch_issue: directed scenarios plus randomized traffic against a reference model.
module tb_instr_fetch_issue;

    logic        clk = 1'b0;
    logic        rst, pc_en, instr_sel, branch_taken;
    logic [15:0] branch_target, imem_addr, imem_data;
    logic [15:0] issue_instr, last3_instr, issue_pc;
    logic        bubble_q, stall_err;
`ifdef FETCH_STATS_EN
    logic [15:0] bubble_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];
    assign imem_data = mem[imem_addr];

    instr_fetch_issue dut (
        .clk           (clk),
        .rst           (rst),
        .pc_en         (pc_en),
        .instr_sel     (instr_sel),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .issue_instr   (issue_instr),
        .last3_instr   (last3_instr),
        .issue_pc      (issue_pc),
        .bubble_q      (bubble_q),
        .stall_err     (stall_err)
`ifdef FETCH_STATS_EN
        ,
        .bubble_cnt    (bubble_cnt),
        .flush_cnt     (flush_cnt)
`endif
    );

    int tests_run = 0;
    int failures  = 0;

    // Reference model: architectural view of the fetch stage.
    logic [15:0] m_pc, m_ipc;
    logic        m_bub, m_err, m_boot;
    int          m_stall, m_bcnt, m_fcnt;
    logic [15:0] m_hist [$];   // last four issued words, oldest first

    task automatic model_reset();
        m_pc = 16'h0000; m_ipc = 16'h0000; m_bub = 1'b1; m_err = 1'b0;
        m_boot = 1'b1; m_stall = 0; m_bcnt = 0; m_fcnt = 0;
        m_hist = '{16'h7000, 16'h7000, 16'h7000, 16'h7000};
    endtask

    task automatic step(input logic en, input logic sel, input logic br, input logic [15:0] tgt);
        logic [15:0] word;
        pc_en = en; instr_sel = sel; branch_taken = br; branch_target = tgt;
        @(posedge clk);
        word = 16'h7000;
        if (m_boot) begin
            m_boot = 1'b0;
            m_bub  = 1'b1;
        end else if (br) begin
            m_pc = tgt; m_bub = 1'b1; m_stall = 0;
            if (m_fcnt < 65535) m_fcnt++;
        end else if (sel) begin
            m_bub = 1'b1;
            if (en) m_pc = m_pc + 16'd1;
            if (m_stall < 4) m_stall++;
            if (m_bcnt < 65535) m_bcnt++;
        end else begin
            word = mem[m_pc]; m_ipc = m_pc; m_bub = 1'b0; m_stall = 0;
            if (en) m_pc = m_pc + 16'd1;
        end
        if (m_stall == 4) m_err = 1'b1;
        m_hist.push_back(word);
        void'(m_hist.pop_front());
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; pc_en = 1'b0; instr_sel = 1'b0; branch_taken = 1'b0; branch_target = '0;
        model_reset();
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; pc_en = 1'b0; instr_sel = 1'b0; branch_taken = 1'b0; branch_target = '0;
        model_reset();
        #1;
        tests_run++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL reset_pc got %h exp 0000", imem_addr); end
        tests_run++; if (issue_instr !== 16'h7000) begin failures++; $display("FAIL reset_issue got %h exp 7000", issue_instr); end
        tests_run++; if (last3_instr !== 16'h7000) begin failures++; $display("FAIL reset_last3 got %h exp 7000", last3_instr); end
        tests_run++; if (issue_pc !== 16'h0000) begin failures++; $display("FAIL reset_issue_pc got %h exp 0000", issue_pc); end
        tests_run++; if (bubble_q !== 1'b1) begin failures++; $display("FAIL reset_bubble got %b exp 1", bubble_q); end
        tests_run++; if (stall_err !== 1'b0) begin failures++; $display("FAIL reset_stall_err got %b exp 0", stall_err); end
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] test_reset done");
    endtask

    task automatic test_boot();
        step(1'b1, 1'b0, 1'b0, 16'h0);
        tests_run++; if (issue_instr !== 16'h7000) begin failures++; $display("FAIL boot_issue got %h exp 7000", issue_instr); end
        tests_run++; if (bubble_q !== 1'b1) begin failures++; $display("FAIL boot_bubble got %b exp 1", bubble_q); end
        tests_run++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL boot_pc_hold got %h exp 0000", imem_addr); end
        step(1'b1, 1'b0, 1'b0, 16'h0);
        tests_run++; if (issue_instr !== 16'h1234) begin failures++; $display("FAIL first_issue got %h exp 1234", issue_instr); end
        tests_run++; if (bubble_q !== 1'b0) begin failures++; $display("FAIL first_bubble got %b exp 0", bubble_q); end
        tests_run++; if (imem_addr !== 16'h0001) begin failures++; $display("FAIL first_pc got %h exp 0001", imem_addr); end
        tests_run++; if (issue_pc !== 16'h0000) begin failures++; $display("FAIL first_issue_pc got %h exp 0000", issue_pc); end
        $display("[TB] test_boot done");
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 16'h0);
        tests_run++; if (imem_addr !== 16'h0005) begin failures++; $display("FAIL stall_pre_pc got %h exp 0005", imem_addr); end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0);
            tests_run++; if (issue_instr !== 16'h7000) begin failures++; $display("FAIL stall_issue%0d got %h exp 7000", i, issue_instr); end
            tests_run++; if (bubble_q !== 1'b1) begin failures++; $display("FAIL stall_bubble%0d got %b exp 1", i, bubble_q); end
            tests_run++; if (imem_addr !== 16'h0005) begin failures++; $display("FAIL stall_pc%0d got %h exp 0005", i, imem_addr); end
        end
        step(1'b1, 1'b0, 1'b0, 16'h0);
        tests_run++; if (issue_instr !== mem[5]) begin failures++; $display("FAIL stall_resume got %h exp %h", issue_instr, mem[5]); end
        tests_run++; if (issue_pc !== 16'h0005) begin failures++; $display("FAIL stall_resume_pc got %h exp 0005", issue_pc); end
        $display("[TB] test_stall done");
    endtask

    task automatic test_branch();
        step(1'b0, 1'b1, 1'b1, 16'h0040);
        tests_run++; if (imem_addr !== 16'h0040) begin failures++; $display("FAIL branch_pc got %h exp 0040", imem_addr); end
        tests_run++; if (issue_instr !== 16'h7000) begin failures++; $display("FAIL branch_nop got %h exp 7000", issue_instr); end
        step(1'b1, 1'b0, 1'b0, 16'h0);
        tests_run++; if (issue_instr !== 16'h1111) begin failures++; $display("FAIL branch_target_issue got %h exp 1111", issue_instr); end
        tests_run++; if (issue_pc !== 16'h0040) begin failures++; $display("FAIL branch_issue_pc got %h exp 0040", issue_pc); end
        $display("[TB] test_branch done");
    endtask

    task automatic test_history();
        step(1'b1, 1'b0, 1'b0, 16'h0);   // issues the EXEC word at 0x41
        tests_run++; if (issue_instr !== 16'h8ABC) begin failures++; $display("FAIL hist_exec_issue got %h exp 8abc", issue_instr); end
        step(1'b0, 1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        tests_run++; if (last3_instr !== 16'h1111) begin failures++; $display("FAIL hist_last3_early got %h exp 1111", last3_instr); end
        step(1'b0, 1'b1, 1'b0, 16'h0);
        tests_run++; if (last3_instr !== 16'h8ABC) begin failures++; $display("FAIL hist_last3_exec got %h exp 8abc", last3_instr); end
        $display("[TB] test_history done");
    endtask

    task automatic test_stall_err();
        apply_reset();
        step(1'b0, 1'b0, 1'b0, 16'h0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0);
            if (i == 3) begin
                tests_run++; if (stall_err !== 1'b0) begin failures++; $display("FAIL stall_err_early got %b exp 0", stall_err); end
            end
        end
        tests_run++; if (stall_err !== 1'b1) begin failures++; $display("FAIL stall_err_set got %b exp 1", stall_err); end
        step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0);
        tests_run++; if (stall_err !== 1'b1) begin failures++; $display("FAIL stall_err_sticky got %b exp 1", stall_err); end
        $display("[TB] test_stall_err done");
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b0, 1'b1, 16'hFFFF);
        tests_run++; if (imem_addr !== 16'hFFFF) begin failures++; $display("FAIL wrap_pre got %h exp ffff", imem_addr); end
        step(1'b1, 1'b0, 1'b0, 16'h0);
        tests_run++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL wrap_pc got %h exp 0000", imem_addr); end
        tests_run++; if (issue_pc !== 16'hFFFF) begin failures++; $display("FAIL wrap_issue_pc got %h exp ffff", issue_pc); end
        $display("[TB] test_wrap done");
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        tests_run++; if (bubble_q !== 1'b1) begin failures++; $display("FAIL async_bubble got %b exp 1", bubble_q); end
        tests_run++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL async_pc got %h exp 0000", imem_addr); end
        tests_run++; if (issue_pc !== 16'h0000) begin failures++; $display("FAIL async_issue_pc got %h exp 0000", issue_pc); end
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] test_async_reset done");
    endtask

`ifdef FETCH_STATS_EN
    task automatic test_stats();
        apply_reset();
        step(1'b0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b1, 16'h0100);
        tests_run++; if (bubble_cnt !== 16'd3) begin failures++; $display("FAIL stats_bubble got %0d exp 3", bubble_cnt); end
        tests_run++; if (flush_cnt !== 16'd1) begin failures++; $display("FAIL stats_flush got %0d exp 1", flush_cnt); end
        $display("[TB] test_stats done");
    endtask
`endif

    task automatic test_random();
        logic en, sel, br;
        logic [15:0] tgt;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            en  = ($urandom_range(3) != 0);
            sel = ($urandom_range(2) == 0);
            br  = ($urandom_range(7) == 0);
            tgt = 16'($urandom);
            step(en, sel, br, tgt);
            tests_run++; if (imem_addr !== m_pc) begin failures++; $display("FAIL rnd_pc c=%0d got %h exp %h", c, imem_addr, m_pc); end
            tests_run++; if (issue_instr !== m_hist[3]) begin failures++; $display("FAIL rnd_issue c=%0d got %h exp %h", c, issue_instr, m_hist[3]); end
            tests_run++; if (last3_instr !== m_hist[0]) begin failures++; $display("FAIL rnd_last3 c=%0d got %h exp %h", c, last3_instr, m_hist[0]); end
            tests_run++; if (bubble_q !== m_bub) begin failures++; $display("FAIL rnd_bubble c=%0d got %b exp %b", c, bubble_q, m_bub); end
            tests_run++; if (stall_err !== m_err) begin failures++; $display("FAIL rnd_stall_err c=%0d got %b exp %b", c, stall_err, m_err); end
            if (!m_bub) begin
                tests_run++; if (issue_pc !== m_ipc) begin failures++; $display("FAIL rnd_issue_pc c=%0d got %h exp %h", c, issue_pc, m_ipc); end
            end
`ifdef FETCH_STATS_EN
            tests_run++; if (bubble_cnt !== 16'(m_bcnt)) begin failures++; $display("FAIL rnd_bubble_cnt c=%0d got %0d exp %0d", c, bubble_cnt, m_bcnt); end
            tests_run++; if (flush_cnt !== 16'(m_fcnt)) begin failures++; $display("FAIL rnd_flush_cnt c=%0d got %0d exp %0d", c, flush_cnt, m_fcnt); end
`endif
            if ($urandom_range(99) == 0) begin
                #2;
                rst = 1'b1;
                model_reset();
                #1;
                tests_run++; if (issue_instr !== 16'h7000) begin failures++; $display("FAIL rnd_rst_issue c=%0d got %h exp 7000", c, issue_instr); end
                @(negedge clk);
                rst = 1'b0;
            end
        end
        $display("[TB] test_random done");
    endtask

    initial begin
        rst = 1'b1; pc_en = 1'b0; instr_sel = 1'b0; branch_taken = 1'b0; branch_target = '0;
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        mem[16'h0000] = 16'h1234;
        mem[16'h0040] = 16'h1111;
        mem[16'h0041] = 16'h8ABC;
        test_reset();
        test_boot();
        test_stall();
        test_branch();
        test_history();
        test_stall_err();
        test_wrap();
        test_async_reset();
`ifdef FETCH_STATS_EN
        test_stats();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
